// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader for the tinyarch instruction memory.
// It receives a framed stream on a simple valid/ready byte channel:
// LEN_LO, LEN_HI, N x (INS_LO, INS_HI), CHK.
// It writes each 9-bit word to imem with a registered one-cycle strobe.
// It holds the core in reset for the whole load.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start                pulse; begins a load from IDLE/DONE/ERR
//   byte_in/byte_valid   host byte channel in
//   byte_ready           loader accepts a byte this cycle
//   imem_we/addr/wdata   instruction-memory write port (registered)
//   cpu_hold             core held in reset while loading or after error
//   busy                 load in progress
//   done/err/err_code    load outcome (levels)
//   words_written        words written in the current/last load
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [8:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [8:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic              accept;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_INS_LO) || (state_q == S_INS_HI) ||
                      (state_q == S_CHK);
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {byte_in, len_q[7:0]};
  assign words_inc  = words_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    chk_d   = chk_q;
    addr_d  = addr_q;
    words_d = words_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          chk_d   = '0;
          addr_d  = '0;
          words_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_in;
          if (32'(len_full) > 32'(DEPTH)) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_INS_LO;
          end
        end
      end
      S_INS_LO: begin
        if (accept) begin
          lo_d    = byte_in;
          chk_d   = chk_q ^ byte_in;
          state_d = S_INS_HI;
        end
      end
      S_INS_HI: begin
        if (accept) begin
          if (byte_in[7:1] != 7'd0) begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {byte_in[0], lo_q};
            chk_d   = chk_q ^ byte_in;
            addr_d  = addr_q + ADDR_W'(1);
            words_d = words_inc;
            state_d = (32'(words_inc) == 32'(len_q)) ? S_CHK : S_INS_LO;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (byte_in == chk_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      chk_q   <= '0;
      addr_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = waddr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) &&
                         (state_q != S_ERR);
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign words_written = words_q;

endmodule
